alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle signed 8x8 multiplier controller that acts as the initiator on the ALU's command interface. It issues the FunSel/A/B operations and consumes OutALU/ZCNO, running a shift-add algorithm through the ALU's ADD, SUB, LSR and CSR functions. It sits between the control logic and the existing ALU, and returns a 16-bit two's-complement product.

## Interface
- No parameters. Width is fixed at 8x8 to 16.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- MulA  in  8  multiplicand, signed; latched on an accepted Start.
- MulB  in  8  multiplier, signed; latched on an accepted Start.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse; Product/Zero are valid from this cycle onward.
- Product  out  16  signed product; held until the next accepted Start.
- Zero  out  1  product equals zero, derived from ALU Z flags.
- AluA  out  8  to ALU A.
- AluB  out  8  to ALU B.
- AluFunSel  out  4  to ALU FunSel.
- OutALU  in  8  from the ALU.
- ZCNO  in  4  from the ALU flags: [3]=Z, [2]=C, [1]=N, [0]=O.

## Operation
- Registers:
  - hi[7:0] is initialised to 0.
  - lo[7:0] is initialised to MulB; it also holds the multiplier bits.
  - mc[7:0] is initialised to MulA.
  - it[2:0] is the iteration counter, initialised to 0.
- States: IDLE, CLR_I, CLR_W, ADD_I, ADD_W, SHH_I, SHH_W, SHL_I, SHL_W, DONE.
- Each ALU op spans two states:
  - In the *_I state, the outputs are driven and the ALU samples them at the end of the cycle.
  - In the *_W state, the outputs are held. OutALU/ZCNO are valid, and the block captures them at the end of the cycle.
- AluA/AluB/AluFunSel are Moore outputs, a function of state and registers only.
- Per iteration, four ops:
  - CLR: FunSel 1100 (LSR), A=0x00. This clears the ALU's internal carry, which ADD uses as carry-in. Nothing is captured.
  - ADD:
    - if lo[0]=0: FunSel 0100, A=hi, B=0x00.
    - if lo[0]=1 and it<7: FunSel 0100, A=hi, B=mc.
    - if lo[0]=1 and it=7: FunSel 0101 (SUB), A=hi, B=mc.
    - Capture hi<=OutALU. The ALU's C becomes bit 8 of the 9-bit signed result.
  - SHH: FunSel 1111 (CSR), A=hi. Capture hi<=OutALU ({C,hi[7:1]}); C becomes the old hi[0]. Record zh<=ZCNO[3].
  - SHL: FunSel 1111, A=lo. Capture lo<=OutALU; record zl<=ZCNO[3].
  - Leaving SHL_W: if it=7, go to DONE; otherwise it<=it+1 and go to CLR_I.
- Arithmetic: 9-bit sign-extended add/sub never overflows. ALU O/N flags are ignored. Result Product={hi,lo}.
- DONE: Product<={hi,lo}, Zero<=zh&zl, Done=1 for one cycle, then IDLE.
- IDLE drives AluFunSel=0000 (pass A), AluA=0x00, AluB=0x00.

## Timing
- Start sampled high in IDLE at edge 0: operands latched, Busy=1 from cycle 0.
- 8 iterations x 4 ops x 2 cycles = 64 cycles. The last capture is at the end of cycle 63.
- DONE in cycle 64: Done=1, Busy=0. The block is back in IDLE in cycle 65.
- Start to Done latency is 64 cycles, exactly, regardless of operands.
- Start while Busy or in DONE: ignored, no queuing. Start may be held high; a new operation is accepted in the first IDLE cycle (cycle 65).
- Changing MulA/MulB while Busy has no effect.
- Reset low at any edge: IDLE next cycle. Outputs: Busy=0, Done=0, Product=0x0000, Zero=0, AluFunSel=0000, AluA=0x00, AluB=0x00, it=0.
- The ALU's internal carry needs no reset, because CLR precedes every ADD.
- ALU flags settle 1 ns after the ALU edge, within the *_W cycle. ZCNO is sampled only at the end of *_W.

## Structure
- Shared package alu_pkg holds:
  - FunSel constants: FS_PASSA=0000, FS_ADD=0100, FS_SUB=0101, FS_LSR=1100, FS_CSR=1111.
  - ZCNO bit indices: Z=3, C=2, N=1, O=0.
  - The state enumeration.
- No sub-module. A single FSM plus datapath registers. The ALU is instantiated beside this block, not inside it.

## Test plan
The bench instantiates the existing ALU alongside this block for all scenarios.
- MulA=3, MulB=5, Start -> Done exactly 64 cycles after Start, Product=0x000F, Zero=0.
- MulA=0x80, MulB=0x80 (-128 x -128) -> Product=0x4000. MulA=0x7F, MulB=0x80 -> Product=0xC080.
- MulA=0xFF, MulB=0xFF -> 0x0001. MulA=0x00, MulB=0xA5 -> 0x0000, Zero=1.
- Start pulsed again at cycles 10 and 64 with different operands -> ignored. Start held high from cycle 0 -> a second operation begins at cycle 65.
- Reset low at cycle 20 mid-operation -> all outputs at reset values next cycle. Then Start with 6 x 7 -> Product=0x002A, no stale carry effect.
- ALU-bus check: per iteration, the FunSel sequence is 1100, 0100/0101, 1111, 1111. Each is held for 2 cycles. 0101 appears only in iteration 7 when MulB[7]=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, flag indices and multiplier FSM states.
package alu_pkg;

  localparam logic [3:0] FS_PASSA = 4'b0000;
  localparam logic [3:0] FS_ADD   = 4'b0100;
  localparam logic [3:0] FS_SUB   = 4'b0101;
  localparam logic [3:0] FS_LSR   = 4'b1100;
  localparam logic [3:0] FS_CSR   = 4'b1111;

  localparam int ZF = 3;
  localparam int CF = 2;
  localparam int NF = 1;
  localparam int OF = 0;

  localparam logic [2:0] LAST_IT = 3'd7;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CLR_I = 4'd1,
    CLR_W = 4'd2,
    ADD_I = 4'd3,
    ADD_W = 4'd4,
    SHH_I = 4'd5,
    SHH_W = 4'd6,
    SHL_I = 4'd7,
    SHL_W = 4'd8,
    DONE  = 4'd9
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - signed 8x8 shift-add multiplier driving an external ALU.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  MulA,
  input  logic [7:0]  MulB,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Product,
  output logic        Zero,
  output logic [7:0]  AluA,
  output logic [7:0]  AluB,
  output logic [3:0]  AluFunSel,
  input  logic [7:0]  OutALU,
  input  logic [3:0]  ZCNO
);

  state_t     state;
  state_t     state_n;
  logic [7:0] hi;
  logic [7:0] lo;
  logic [7:0] mc;
  logic [2:0] it;
  logic       zh;
  logic       zl;
  logic       last_it;

  logic unused_flags;
  assign unused_flags = ^{ZCNO[CF], ZCNO[NF], ZCNO[OF]};

  assign last_it = (it == LAST_IT);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    AluFunSel = FS_PASSA;
    AluA      = 8'h00;
    AluB      = 8'h00;
    case (state)
      IDLE: begin
        if (Start) state_n = CLR_I;
      end
      CLR_I, CLR_W: begin
        Busy      = 1'b1;
        AluFunSel = FS_LSR;
        state_n   = (state == CLR_I) ? CLR_W : ADD_I;
      end
      ADD_I, ADD_W: begin
        // The sign bit of the multiplier carries negative weight, so the last partial product is subtracted.
        Busy      = 1'b1;
        AluFunSel = (lo[0] && last_it) ? FS_SUB : FS_ADD;
        AluA      = hi;
        AluB      = lo[0] ? mc : 8'h00;
        state_n   = (state == ADD_I) ? ADD_W : SHH_I;
      end
      SHH_I, SHH_W: begin
        Busy      = 1'b1;
        AluFunSel = FS_CSR;
        AluA      = hi;
        state_n   = (state == SHH_I) ? SHH_W : SHL_I;
      end
      SHL_I: begin
        Busy      = 1'b1;
        AluFunSel = FS_CSR;
        AluA      = lo;
        state_n   = SHL_W;
      end
      SHL_W: begin
        Busy      = 1'b1;
        AluFunSel = FS_CSR;
        AluA      = lo;
        state_n   = last_it ? DONE : CLR_I;
      end
      DONE: begin
        Done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      hi      <= 8'h00;
      lo      <= 8'h00;
      mc      <= 8'h00;
      it      <= 3'd0;
      zh      <= 1'b0;
      zl      <= 1'b0;
      Product <= 16'h0000;
      Zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            hi <= 8'h00;
            lo <= MulB;
            mc <= MulA;
            it <= 3'd0;
          end
        end
        ADD_W: hi <= OutALU;
        SHH_W: begin
          hi <= OutALU;
          zh <= ZCNO[ZF];
        end
        SHL_W: begin
          lo <= OutALU;
          zl <= ZCNO[ZF];
          // Product is loaded on the way into DONE so it is already valid while Done is high.
          if (last_it) begin
            Product <= {hi, OutALU};
            Zero    <= zh & ZCNO[ZF];
          end else begin
            it <= it + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq with a behavioural ALU beside it.
module tb_alu_mul_seq;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  MulA = 8'h00;
  logic [7:0]  MulB = 8'h00;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;
  logic        Zero;
  logic [7:0]  AluA;
  logic [7:0]  AluB;
  logic [3:0]  AluFunSel;
  logic [7:0]  OutALU = 8'h00;
  logic [3:0]  ZCNO = 4'h0;

  always #5 CLK = ~CLK;

  alu_mul_seq dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MulA(MulA), .MulB(MulB),
    .Busy(Busy), .Done(Done), .Product(Product), .Zero(Zero),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel),
    .OutALU(OutALU), .ZCNO(ZCNO)
  );

  // ALU stand-in: registered result and flags, strobed once per two-cycle op; carry starts stale.
  logic alu_c = 1'b1;
  logic alu_phase = 1'b0;
  always @(posedge CLK) begin
    logic [8:0] s9;
    logic [7:0] r;
    logic       c;
    alu_phase <= Busy ? ~alu_phase : 1'b0;
    if (Busy && !alu_phase) begin
      r = AluA;
      c = alu_c;
      case (AluFunSel)
        4'b0100: begin s9 = {AluA[7], AluA} + {AluB[7], AluB} + {8'h00, alu_c}; r = s9[7:0]; c = s9[8]; end
        4'b0101: begin s9 = {AluA[7], AluA} - {AluB[7], AluB}; r = s9[7:0]; c = s9[8]; end
        4'b1100: begin r = {1'b0, AluA[7:1]}; c = AluA[0]; end
        4'b1111: begin r = {alu_c, AluA[7:1]}; c = AluA[0]; end
        default: ;
      endcase
      OutALU <= r;
      ZCNO   <= {(r == 8'h00), c, r[7], 1'b0};
      alu_c  <= c;
    end
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [3:0] fs_log[64];
  logic [7:0] ab_log[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Sample from the current negedge (cycle 0) until Done, logging the ALU bus.
  task automatic wait_done(input bit noise, output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (cyc < 200) begin
      if (cyc < 64) begin
        fs_log[cyc] = AluFunSel;
        ab_log[cyc] = AluB;
      end
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (noise && cyc == 10) begin
        Start = 1'b1;
        MulA = 8'($urandom);
        MulB = 8'($urandom);
      end else if (noise && cyc == 11) begin
        Start = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic check_bus(input string tag, input logic [7:0] a, input logic [7:0] b);
    int nmis = 0;
    logic [3:0] efs;
    logic [7:0] eab;
    for (int k = 0; k < 64; k++) begin
      int i = k / 8;
      int op = (k % 8) / 2;
      efs = 4'b1111;
      eab = 8'h00;
      if (op == 0) efs = 4'b1100;
      if (op == 1) begin
        efs = (b[i] && i == 7) ? 4'b0101 : 4'b0100;
        eab = b[i] ? a : 8'h00;
      end
      if (fs_log[k] !== efs || ab_log[k] !== eab) nmis++;
    end
    check({tag, "_bus"}, nmis, 0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input bit noise);
    int  cyc;
    bit  seen;
    logic [15:0] p;
    p = ref_prod(a, b);
    @(negedge CLK);
    MulA = a;
    MulB = b;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    MulA = ~a;
    MulB = b ^ 8'h5A;
    check({tag, "_busy"}, Busy, 1'b1);
    wait_done(noise, cyc, seen);
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, cyc, 64);
    check({tag, "_product"}, Product, p);
    check({tag, "_zero"}, Zero, (p == 16'h0000));
    check({tag, "_busy_in_done"}, Busy, 1'b0);
    check_bus(tag, a, b);
    if (noise) begin
      Start = 1'b1;
      MulA = 8'($urandom);
      MulB = 8'($urandom);
      @(negedge CLK);
      Start = 1'b0;
      @(negedge CLK);
      check({tag, "_start_in_done_ignored"}, Busy, 1'b0);
      check({tag, "_product_held"}, Product, p);
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    logic [7:0] ra;
    logic [7:0] rb;

    repeat (3) @(negedge CLK);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_product", Product, 16'h0000);
    check("rst_zero", Zero, 1'b0);
    check("rst_funsel", AluFunSel, 4'b0000);
    check("rst_alua", AluA, 8'h00);
    check("rst_alub", AluB, 8'h00);
    Reset = 1'b1;

    run_op("m3x5", 8'h03, 8'h05, 1'b0);
    run_op("m80x80", 8'h80, 8'h80, 1'b0);
    run_op("m7fx80", 8'h7F, 8'h80, 1'b0);
    run_op("mffxff", 8'hFF, 8'hFF, 1'b0);
    run_op("m00xa5", 8'h00, 8'hA5, 1'b0);
    run_op("noise", 8'h13, 8'hE7, 1'b1);

    // Start held high across a whole operation restarts in the first IDLE cycle.
    @(negedge CLK);
    MulA = 8'h21;
    MulB = 8'h9C;
    Start = 1'b1;
    @(negedge CLK);
    MulA = 8'hF3;
    MulB = 8'h0B;
    wait_done(1'b0, cyc, seen);
    check("held_first_latency", cyc, 64);
    check("held_first_product", Product, ref_prod(8'h21, 8'h9C));
    @(negedge CLK);
    check("held_idle_gap", Busy, 1'b0);
    @(negedge CLK);
    check("held_restart_busy", Busy, 1'b1);
    Start = 1'b0;
    wait_done(1'b0, cyc, seen);
    check("held_second_latency", cyc, 64);
    check("held_second_product", Product, ref_prod(8'hF3, 8'h0B));

    // Reset mid-operation.
    @(negedge CLK);
    MulA = 8'h55;
    MulB = 8'h33;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (20) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_done", Done, 1'b0);
    check("midrst_product", Product, 16'h0000);
    check("midrst_zero", Zero, 1'b0);
    check("midrst_funsel", AluFunSel, 4'b0000);
    check("midrst_alua", AluA, 8'h00);
    check("midrst_alub", AluB, 8'h00);
    Reset = 1'b1;
    run_op("m6x7", 8'h06, 8'h07, 1'b0);
    check("m6x7_value", Product, 16'h002A);

    for (int n = 0; n < 8; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op($sformatf("rnd%0d_%02h_%02h", n, ra, rb), ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
